// File: rtl/ip_tx_framer_pkg.sv
// Shared types and constants for the IPv4 transmit framer and its checksum accumulator.
package ip_tx_framer_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CSUM    = 3'd1,
    ST_FOLD    = 3'd2,
    ST_HEADER  = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_DRAIN   = 3'd5
  } ip_tx_state_t;

  localparam int unsigned IPV4_HDR_LEN = 20;
  localparam byte_t       IPV4_VER_IHL = 8'h45;
  localparam int unsigned CSUM_WORDS   = 9;
  localparam int unsigned FOLD_STEPS   = 2;

  // One end-around-carry step: add the upper half back into the lower half.
  function automatic logic [31:0] ip_csum_fold(input logic [31:0] sum);
    return {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
  endfunction

endpackage

// File: rtl/ip_checksum_acc.sv
// Sequential ones'-complement accumulator: clear, add a 16-bit word, fold carries, read ~sum.
module ip_checksum_acc
  import ip_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_add,
  input  logic        i_fold,
  input  logic [15:0] i_word,
  output logic [15:0] o_result
);

  logic [31:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sum <= 32'h0000_0000;
    end else if (i_add) begin
      r_sum <= r_sum + {16'h0000, i_word};
    end else if (i_fold) begin
      r_sum <= ip_csum_fold(r_sum);
    end
  end

  assign o_result = ~r_sum[15:0];

endmodule

// File: rtl/ip_tx_framer.sv
// IPv4 transmit framer: checksums a latched header, emits it byte-wise, then passes the payload through.
// Handshake: a byte moves on any clock edge where its valid and ready are both high; a presented byte holds until it moves.
module ip_tx_framer
  import ip_tx_framer_pkg::*;
#(
  parameter logic [31:0] IP_ADDRESS         = 32'hC0A80101,
  parameter logic [7:0]  TRANSPORT_PROTOCOL = 8'd17,
  parameter logic [7:0]  TTL                = 8'h40,
  parameter logic [15:0] MAX_PAYLOAD        = 16'd1480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_start,
  input  logic [15:0]  tx_payload_len,
  input  logic [31:0]  tx_dest_ip,
  output logic         tx_busy,
  input  byte_t        payload_data_in,
  input  logic         payload_valid,
  input  logic         payload_eof,
  output logic         payload_ready,
  output byte_t        ip_data_out,
  output logic         ip_byte_valid,
  input  logic         ip_ready,
  output logic         ip_eof,
  output logic         ip_err,
  output ip_tx_state_t dbg_state
);

  ip_tx_state_t r_state, w_next_state;
  logic [15:0]  r_len, r_total_len, r_ident, r_pay_cnt;
  logic [31:0]  r_dst;
  logic [4:0]   r_idx;
  logic         r_req_err;

  logic         w_len_ok, w_start_ok, w_start_bad;
  logic         w_hdr_xfer, w_pay_xfer, w_pay_last, w_good_end, w_pay_err;
  logic [15:0]  w_csum_word, w_csum;
  byte_t        w_hdr_byte;

  assign w_len_ok    = (tx_payload_len != 16'd0) && (tx_payload_len <= MAX_PAYLOAD);
  assign w_start_ok  = (r_state == ST_IDLE) && tx_start && w_len_ok;
  assign w_start_bad = (r_state == ST_IDLE) && tx_start && !w_len_ok;
  assign w_hdr_xfer  = (r_state == ST_HEADER) && ip_ready;
  assign w_pay_xfer  = (r_state == ST_PAYLOAD) && payload_valid && ip_ready;
  assign w_pay_last  = ((r_pay_cnt + 16'd1) == r_len);
  assign w_good_end  = w_pay_xfer && payload_eof && w_pay_last;
  // Any disagreement between eof and the byte count on a moved byte is an error.
  assign w_pay_err   = w_pay_xfer && (payload_eof != w_pay_last);

  assign tx_busy   = (r_state != ST_IDLE);
  assign dbg_state = r_state;

  ip_checksum_acc u_csum (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start_ok),
    .i_add    (r_state == ST_CSUM),
    .i_fold   (r_state == ST_FOLD),
    .i_word   (w_csum_word),
    .o_result (w_csum)
  );

  always_comb begin
    w_csum_word = 16'h0000;
    case (r_idx)
      5'd0:    w_csum_word = {IPV4_VER_IHL, 8'h00};
      5'd1:    w_csum_word = r_total_len;
      5'd2:    w_csum_word = r_ident;
      5'd3:    w_csum_word = 16'h0000;
      5'd4:    w_csum_word = {TTL, TRANSPORT_PROTOCOL};
      5'd5:    w_csum_word = IP_ADDRESS[31:16];
      5'd6:    w_csum_word = IP_ADDRESS[15:0];
      5'd7:    w_csum_word = r_dst[31:16];
      5'd8:    w_csum_word = r_dst[15:0];
      default: w_csum_word = 16'h0000;
    endcase
  end

  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_idx)
      5'd0:    w_hdr_byte = IPV4_VER_IHL;
      5'd2:    w_hdr_byte = r_total_len[15:8];
      5'd3:    w_hdr_byte = r_total_len[7:0];
      5'd4:    w_hdr_byte = r_ident[15:8];
      5'd5:    w_hdr_byte = r_ident[7:0];
      5'd8:    w_hdr_byte = TTL;
      5'd9:    w_hdr_byte = TRANSPORT_PROTOCOL;
      5'd10:   w_hdr_byte = w_csum[15:8];
      5'd11:   w_hdr_byte = w_csum[7:0];
      5'd12:   w_hdr_byte = IP_ADDRESS[31:24];
      5'd13:   w_hdr_byte = IP_ADDRESS[23:16];
      5'd14:   w_hdr_byte = IP_ADDRESS[15:8];
      5'd15:   w_hdr_byte = IP_ADDRESS[7:0];
      5'd16:   w_hdr_byte = r_dst[31:24];
      5'd17:   w_hdr_byte = r_dst[23:16];
      5'd18:   w_hdr_byte = r_dst[15:8];
      5'd19:   w_hdr_byte = r_dst[7:0];
      default: w_hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    payload_ready = 1'b0;
    ip_byte_valid = 1'b0;
    ip_data_out   = 8'h00;
    ip_eof        = 1'b0;
    ip_err        = r_req_err;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_next_state = ST_CSUM;
      end
      ST_CSUM: begin
        if (r_idx == 5'(CSUM_WORDS - 1)) w_next_state = ST_FOLD;
      end
      ST_FOLD: begin
        if (r_idx == 5'(FOLD_STEPS - 1)) w_next_state = ST_HEADER;
      end
      ST_HEADER: begin
        ip_byte_valid = 1'b1;
        ip_data_out   = w_hdr_byte;
        if (w_hdr_xfer && (r_idx == 5'(IPV4_HDR_LEN - 1))) w_next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        payload_ready = ip_ready;
        ip_byte_valid = payload_valid;
        ip_data_out   = payload_data_in;
        ip_eof        = payload_valid && payload_eof && w_pay_last;
        ip_err        = r_req_err || w_pay_err;
        if (w_pay_xfer) begin
          if (payload_eof)     w_next_state = ST_IDLE;
          else if (w_pay_last) w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        payload_ready = 1'b1;
        if (payload_valid && payload_eof) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= 16'h0000;
      r_total_len <= 16'h0000;
      r_dst       <= 32'h0000_0000;
      r_ident     <= 16'h0000;
      r_pay_cnt   <= 16'h0000;
      r_idx       <= 5'd0;
      r_req_err   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_req_err <= w_start_bad;
      if (w_start_ok) begin
        r_len       <= tx_payload_len;
        r_total_len <= tx_payload_len + 16'(IPV4_HDR_LEN);
        r_dst       <= tx_dest_ip;
        r_pay_cnt   <= 16'h0000;
        r_idx       <= 5'd0;
      end
      // r_idx is reused as word index, fold step and header byte index.
      case (r_state)
        ST_CSUM:   r_idx <= (r_idx == 5'(CSUM_WORDS - 1)) ? 5'd0 : r_idx + 5'd1;
        ST_FOLD:   r_idx <= (r_idx == 5'(FOLD_STEPS - 1)) ? 5'd0 : r_idx + 5'd1;
        ST_HEADER: if (w_hdr_xfer) r_idx <= (r_idx == 5'(IPV4_HDR_LEN - 1)) ? 5'd0 : r_idx + 5'd1;
        default:   ;
      endcase
      if (w_pay_xfer) r_pay_cnt <= r_pay_cnt + 16'd1;
      if (w_good_end) r_ident <= r_ident + 16'd1;
    end
  end

endmodule
